// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared core types: XLEN and the fetch-queue entry
package risc_pkg;

   localparam int XLEN = 32;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
      logic            filled;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_ptr.sv
// rtl/fetch_ptr.sv - wrap-around queue pointer with flush clear
module fetch_ptr #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     nrst,
   input  logic                     clr,
   input  logic                     inc,
   output logic [$clog2(DEPTH)-1:0] ptr
);

   localparam int PW = $clog2(DEPTH);

   logic [PW-1:0] ptr_q;
   logic [PW-1:0] ptr_d;

   // DEPTH is a power of two, so the natural overflow is the wrap
   always_comb begin
      ptr_d = ptr_q;
      if (clr) begin
         ptr_d = '0;
      end else if (inc) begin
         ptr_d = ptr_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch queue between PC, imem and decode
module fetch_queue
   import risc_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            nrst,
   input  logic [XLEN-1:0] pc_in,
   input  logic            redirect,
   output logic            pc_stall,
   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            inst_valid,
   output logic [XLEN-1:0] inst_data,
   output logic [XLEN-1:0] inst_pc,
   input  logic            inst_ready
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   fetch_entry_t entries_q [DEPTH];
   fetch_entry_t entries_d [DEPTH];

   logic [CW-1:0] occ_q, occ_d;
   logic [CW-1:0] unfilled_q, unfilled_d;
   logic [CW-1:0] drop_cnt_q, drop_cnt_d;

   logic [PW-1:0] head, tail, fill_ptr;
   logic          req_fire, pop, rsp_fill, rsp_drop;

   assign imem_req_valid = nrst & ~redirect & (occ_q < CW'(DEPTH)) & (drop_cnt_q == '0);
   assign imem_req_addr  = pc_in;
   assign req_fire       = imem_req_valid & imem_req_ready;
   assign pc_stall       = ~req_fire & ~redirect;

   assign inst_valid = nrst & entries_q[head].filled;
   assign inst_data  = entries_q[head].inst;
   assign inst_pc    = entries_q[head].pc;
   assign pop        = inst_valid & inst_ready & ~redirect;

   // Responses return in order, so the oldest unfilled entry is tracked by its own pointer
   assign rsp_fill = imem_rsp_valid & (drop_cnt_q == '0) & ~redirect & (unfilled_q != '0);
   assign rsp_drop = imem_rsp_valid & (drop_cnt_q != '0);

   fetch_ptr #(.DEPTH(DEPTH)) u_head_ptr (
      .clk  (clk),
      .nrst (nrst),
      .clr  (redirect),
      .inc  (pop),
      .ptr  (head)
   );

   fetch_ptr #(.DEPTH(DEPTH)) u_tail_ptr (
      .clk  (clk),
      .nrst (nrst),
      .clr  (redirect),
      .inc  (req_fire),
      .ptr  (tail)
   );

   fetch_ptr #(.DEPTH(DEPTH)) u_fill_ptr (
      .clk  (clk),
      .nrst (nrst),
      .clr  (redirect),
      .inc  (rsp_fill),
      .ptr  (fill_ptr)
   );

   always_comb begin
      entries_d  = entries_q;
      occ_d      = occ_q + CW'(req_fire) - CW'(pop);
      unfilled_d = unfilled_q + CW'(req_fire) - CW'(rsp_fill);
      drop_cnt_d = drop_cnt_q - CW'(rsp_drop);

      if (req_fire) begin
         entries_d[tail] = '{pc: pc_in, inst: '0, filled: 1'b0};
      end
      if (rsp_fill) begin
         entries_d[fill_ptr].inst   = imem_rsp_data;
         entries_d[fill_ptr].filled = 1'b1;
      end
      if (pop) begin
         entries_d[head].filled = 1'b0;
      end

      // Every request still in flight must be swallowed; a same-cycle response is one of them
      if (redirect) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_d[i].filled = 1'b0;
         end
         occ_d      = '0;
         unfilled_d = '0;
         drop_cnt_d = drop_cnt_q + unfilled_q - CW'(imem_rsp_valid);
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         occ_q      <= '0;
         unfilled_q <= '0;
         drop_cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            entries_q[i].filled <= 1'b0;
         end
      end else begin
         occ_q      <= occ_d;
         unfilled_q <= unfilled_d;
         drop_cnt_q <= drop_cnt_d;
         entries_q  <= entries_d;
      end
   end

   rsp_has_owner: assert property (@(posedge clk) disable iff (!nrst)
      (imem_rsp_valid && drop_cnt_q == '0) |-> (unfilled_q != '0));

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - table-driven checks of fetch_queue (DEPTH = 4)
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        nrst;
   logic [31:0] pc_in;
   logic        redirect;
   logic        pc_stall;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        inst_ready;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fetch_queue #(.DEPTH(4)) dut (
      .clk            (clk),
      .nrst           (nrst),
      .pc_in          (pc_in),
      .redirect       (redirect),
      .pc_stall       (pc_stall),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst_valid     (inst_valid),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .inst_ready     (inst_ready)
   );

   typedef struct {
      logic        rst_n;
      logic [31:0] pc;
      logic        redir;
      logic        rdy;
      logic        rv;
      logic [31:0] rpc;
      logic        ir;
      logic        e_rv;
      logic        e_st;
      logic        e_iv;
      logic [31:0] e_ipc;
      int          e_occ;
      int          e_drop;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [31:0] word_of(input logic [31:0] pc);
      return 32'hD000_0000 | pc;
   endfunction

   function automatic vec_t mk(input logic rst_n, input logic [31:0] pc, input logic redir,
                               input logic rdy, input logic rv, input logic [31:0] rpc,
                               input logic ir, input logic e_rv, input logic e_st,
                               input logic e_iv, input logic [31:0] e_ipc,
                               input int e_occ, input int e_drop);
      vec_t v;
      v.rst_n = rst_n; v.pc = pc; v.redir = redir; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
      v.ir = ir; v.e_rv = e_rv; v.e_st = e_st; v.e_iv = e_iv; v.e_ipc = e_ipc;
      v.e_occ = e_occ; v.e_drop = e_drop;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   initial begin
      bit seen;

      nrst = 1'b0; pc_in = '0; redirect = 1'b0; imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0; imem_rsp_data = '0; inst_ready = 1'b0;
      repeat (2) @(negedge clk);

      //             rst pc        rd rdy rv rpc       ir  erv est eiv eipc      occ drop
      tbl.push_back(mk(0, 32'h000, 0, 1, 0, 32'h000, 0,  0, 1, 0, 32'h000, 0, 0));
      tbl.push_back(mk(1, 32'h000, 0, 1, 0, 32'h000, 1,  1, 0, 0, 32'h000, 0, 0));
      tbl.push_back(mk(1, 32'h004, 0, 1, 1, 32'h000, 1,  1, 0, 0, 32'h000, 1, 0));
      tbl.push_back(mk(1, 32'h008, 0, 1, 1, 32'h004, 1,  1, 0, 1, 32'h000, 2, 0));
      tbl.push_back(mk(1, 32'h00C, 0, 1, 1, 32'h008, 1,  1, 0, 1, 32'h004, 2, 0));
      tbl.push_back(mk(1, 32'h010, 0, 1, 1, 32'h00C, 1,  1, 0, 1, 32'h008, 2, 0));
      tbl.push_back(mk(1, 32'h014, 0, 1, 1, 32'h010, 0,  1, 0, 1, 32'h00C, 2, 0));
      tbl.push_back(mk(1, 32'h018, 0, 1, 1, 32'h014, 0,  1, 0, 1, 32'h00C, 3, 0));
      tbl.push_back(mk(1, 32'h01C, 0, 1, 1, 32'h018, 0,  0, 1, 1, 32'h00C, 4, 0));
      tbl.push_back(mk(1, 32'h01C, 0, 1, 0, 32'h000, 0,  0, 1, 1, 32'h00C, 4, 0));
      tbl.push_back(mk(1, 32'h01C, 0, 1, 0, 32'h000, 1,  0, 1, 1, 32'h00C, 4, 0));
      tbl.push_back(mk(1, 32'h01C, 0, 1, 0, 32'h000, 0,  1, 0, 1, 32'h010, 3, 0));
      tbl.push_back(mk(1, 32'h020, 0, 1, 0, 32'h000, 0,  0, 1, 1, 32'h010, 4, 0));
      tbl.push_back(mk(1, 32'h020, 0, 1, 1, 32'h01C, 1,  0, 1, 1, 32'h010, 4, 0));
      tbl.push_back(mk(1, 32'h020, 0, 0, 0, 32'h000, 1,  1, 1, 1, 32'h014, 3, 0));
      tbl.push_back(mk(1, 32'h020, 0, 0, 0, 32'h000, 1,  1, 1, 1, 32'h018, 2, 0));
      tbl.push_back(mk(1, 32'h020, 0, 0, 0, 32'h000, 1,  1, 1, 1, 32'h01C, 1, 0));
      tbl.push_back(mk(1, 32'h020, 0, 1, 0, 32'h000, 1,  1, 0, 0, 32'h000, 0, 0));
      tbl.push_back(mk(1, 32'h024, 0, 1, 0, 32'h000, 1,  1, 0, 0, 32'h000, 1, 0));
      tbl.push_back(mk(1, 32'h028, 1, 1, 0, 32'h000, 1,  0, 0, 0, 32'h000, 2, 0));
      tbl.push_back(mk(1, 32'h100, 0, 1, 1, 32'h020, 1,  0, 1, 0, 32'h000, 0, 2));
      tbl.push_back(mk(1, 32'h100, 0, 1, 1, 32'h024, 1,  0, 1, 0, 32'h000, 0, 1));
      tbl.push_back(mk(1, 32'h100, 0, 1, 0, 32'h000, 1,  1, 0, 0, 32'h000, 0, 0));
      tbl.push_back(mk(1, 32'h104, 0, 1, 1, 32'h100, 1,  1, 0, 0, 32'h000, 1, 0));
      tbl.push_back(mk(1, 32'h108, 0, 0, 0, 32'h000, 1,  1, 1, 1, 32'h100, 2, 0));
      tbl.push_back(mk(1, 32'h108, 0, 1, 0, 32'h000, 1,  1, 0, 0, 32'h000, 1, 0));
      tbl.push_back(mk(1, 32'h10C, 1, 1, 1, 32'h104, 1,  0, 0, 0, 32'h000, 2, 0));
      tbl.push_back(mk(1, 32'h200, 0, 1, 0, 32'h000, 1,  0, 1, 0, 32'h000, 0, 1));
      tbl.push_back(mk(1, 32'h200, 0, 1, 1, 32'h108, 1,  0, 1, 0, 32'h000, 0, 1));
      tbl.push_back(mk(1, 32'h200, 0, 1, 0, 32'h000, 1,  1, 0, 0, 32'h000, 0, 0));
      tbl.push_back(mk(1, 32'h204, 0, 1, 1, 32'h200, 0,  1, 0, 0, 32'h000, 1, 0));
      tbl.push_back(mk(1, 32'h208, 0, 1, 1, 32'h204, 0,  1, 0, 1, 32'h200, 2, 0));
      tbl.push_back(mk(1, 32'h20C, 1, 1, 0, 32'h000, 1,  0, 0, 1, 32'h200, 3, 0));
      tbl.push_back(mk(1, 32'h300, 0, 1, 1, 32'h208, 1,  0, 1, 0, 32'h000, 0, 1));
      tbl.push_back(mk(1, 32'h300, 0, 1, 0, 32'h000, 1,  1, 0, 0, 32'h000, 0, 0));
      tbl.push_back(mk(1, 32'h304, 0, 1, 1, 32'h300, 1,  1, 0, 0, 32'h000, 1, 0));
      tbl.push_back(mk(1, 32'h308, 0, 1, 1, 32'h304, 0,  1, 0, 1, 32'h300, 2, 0));
      tbl.push_back(mk(0, 32'h30C, 0, 1, 0, 32'h000, 0,  0, 1, 0, 32'h000, 3, 0));
      tbl.push_back(mk(1, 32'h000, 0, 1, 0, 32'h000, 1,  1, 0, 0, 32'h000, 0, 0));
      tbl.push_back(mk(1, 32'h004, 0, 1, 1, 32'h000, 1,  1, 0, 0, 32'h000, 1, 0));
      tbl.push_back(mk(1, 32'h008, 0, 1, 0, 32'h000, 1,  1, 0, 1, 32'h000, 2, 0));

      foreach (tbl[i]) begin
         nrst           = tbl[i].rst_n;
         pc_in          = tbl[i].pc;
         redirect       = tbl[i].redir;
         imem_req_ready = tbl[i].rdy;
         imem_rsp_valid = tbl[i].rv;
         imem_rsp_data  = tbl[i].rv ? word_of(tbl[i].rpc) : 32'h0;
         inst_ready     = tbl[i].ir;
         #1;
         chk($sformatf("v%0d req_valid", i), 32'(imem_req_valid), 32'(tbl[i].e_rv));
         chk($sformatf("v%0d pc_stall", i), 32'(pc_stall), 32'(tbl[i].e_st));
         chk($sformatf("v%0d inst_valid", i), 32'(inst_valid), 32'(tbl[i].e_iv));
         chk($sformatf("v%0d occupancy", i), 32'(dut.occ_q), 32'(tbl[i].e_occ));
         chk($sformatf("v%0d drop_cnt", i), 32'(dut.drop_cnt_q), 32'(tbl[i].e_drop));
         if (tbl[i].e_rv) begin
            chk($sformatf("v%0d req_addr", i), imem_req_addr, tbl[i].pc);
         end
         if (tbl[i].e_iv) begin
            chk($sformatf("v%0d inst_pc", i), inst_pc, tbl[i].e_ipc);
            chk($sformatf("v%0d inst_data", i), inst_data, word_of(tbl[i].e_ipc));
         end
         @(negedge clk);
      end

      // Entries 0x4 and 0x8 are outstanding: a response must not bypass to decode
      pc_in = 32'h00C; redirect = 1'b0; imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1; imem_rsp_data = word_of(32'h004); inst_ready = 1'b0;
      #1;
      chk("bypass inst_valid", 32'(inst_valid), 32'h0);
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 4 && !seen; c++) begin
         #1;
         if (inst_valid) begin
            seen = 1'b1;
            chk("latency cycles", 32'(c), 32'h0);
            chk("late inst_pc", inst_pc, 32'h004);
            chk("late inst_data", inst_data, word_of(32'h004));
         end else begin
            @(negedge clk);
         end
      end
      if (!seen) begin
         chk("inst_valid timeout", 32'h0, 32'h1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
